// File: rtl/adder_pkg.sv
// Shared types and golden model for the pipelined add/subtract unit.
package adder_pkg;

  localparam int ADDER_WIDTH = 32;
  localparam int ADDER_TAG_W = 4;
  localparam int ADDER_MSB   = ADDER_WIDTH - 1;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } adder_op_e;

  typedef struct packed {
    logic [ADDER_WIDTH-1:0] result;
    logic                   carry;
    logic                   overflow;
    logic                   zero;
    logic [ADDER_TAG_W-1:0] tag;
  } adder_result_s;

  // Golden result from plain arithmetic; SUB carry means "no borrow" (a >= b unsigned).
  function automatic adder_result_s ref_add(input logic [ADDER_WIDTH-1:0] a,
                                            input logic [ADDER_WIDTH-1:0] b,
                                            input adder_op_e              op);
    adder_result_s        r;
    logic [ADDER_WIDTH:0] wide;
    r    = '0;
    wide = '0;
    if (op == OP_ADD) begin
      wide       = {1'b0, a} + {1'b0, b};
      r.result   = wide[ADDER_WIDTH-1:0];
      r.carry    = wide[ADDER_WIDTH];
      r.overflow = (a[ADDER_MSB] == b[ADDER_MSB]) && (r.result[ADDER_MSB] != a[ADDER_MSB]);
    end else begin
      r.result   = a - b;
      r.carry    = (a >= b);
      r.overflow = (a[ADDER_MSB] != b[ADDER_MSB]) && (r.result[ADDER_MSB] != a[ADDER_MSB]);
    end
    r.zero = (r.result == '0);
    return r;
  endfunction

endpackage

// File: rtl/adder_seg_stage.sv
// One pipeline stage: resolves a single carry-chain segment and holds it behind
// a valid/ready register with bubble collapsing.
module adder_seg_stage
  import adder_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TAG_W   = 4,
  parameter int SEG_W   = 8,
  parameter int SEG_IDX = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] sum,
  input  logic             carry,
  input  adder_op_e        op,
  input  logic [TAG_W-1:0] tag,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_q,
  output adder_op_e        op_q,
  output logic [TAG_W-1:0] tag_q
);

  localparam int LO = SEG_IDX * SEG_W;

  logic [SEG_W:0]   seg_sum;
  logic [WIDTH-1:0] sum_next;
  logic             load;

  assign up_ready = ~dn_valid | dn_ready;
  assign load     = up_valid & up_ready;
  assign seg_sum  = {1'b0, a[LO +: SEG_W]} + {1'b0, b[LO +: SEG_W]} + {{SEG_W{1'b0}}, carry};

  always_comb begin
    sum_next                = sum;
    sum_next[LO +: SEG_W]   = seg_sum[SEG_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dn_valid <= 1'b0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
    end
  end

  // Data only moves on a real transfer so a stalled result stays put.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      op_q    <= OP_ADD;
      tag_q   <= '0;
    end else if (load) begin
      a_q     <= a;
      b_q     <= b;
      sum_q   <= sum_next;
      carry_q <= seg_sum[SEG_W];
      op_q    <= op;
      tag_q   <= tag;
    end
  end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined integer add/subtract unit: carry chain split into STAGES segments,
// valid/ready on both sides, flags derived from the last stage.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  adder_op_e        in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SEG_W = WIDTH / STAGES;

  logic             v     [0:STAGES];
  logic             rdy   [0:STAGES];
  logic [WIDTH-1:0] a_s   [0:STAGES];
  logic [WIDTH-1:0] b_s   [0:STAGES];
  logic [WIDTH-1:0] sum_s [0:STAGES];
  logic             c_s   [0:STAGES];
  adder_op_e        op_s  [0:STAGES];
  logic [TAG_W-1:0] tag_s [0:STAGES];
  logic             unused_bits;

  // Subtraction enters the chain as A + ~B + 1, so later stages never see the op.
  assign v[0]     = in_valid;
  assign a_s[0]   = in_a;
  assign b_s[0]   = (in_op == OP_SUB) ? ~in_b : in_b;
  assign sum_s[0] = '0;
  assign c_s[0]   = (in_op == OP_SUB);
  assign op_s[0]  = in_op;
  assign tag_s[0] = in_tag;

  assign rdy[STAGES] = out_ready;
  assign in_ready    = rdy[0] & ~rst;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    adder_seg_stage #(
      .WIDTH  (WIDTH),
      .TAG_W  (TAG_W),
      .SEG_W  (SEG_W),
      .SEG_IDX(i)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .up_valid(v[i]),
      .up_ready(rdy[i]),
      .a       (a_s[i]),
      .b       (b_s[i]),
      .sum     (sum_s[i]),
      .carry   (c_s[i]),
      .op      (op_s[i]),
      .tag     (tag_s[i]),
      .dn_valid(v[i+1]),
      .dn_ready(rdy[i+1]),
      .a_q     (a_s[i+1]),
      .b_q     (b_s[i+1]),
      .sum_q   (sum_s[i+1]),
      .carry_q (c_s[i+1]),
      .op_q    (op_s[i+1]),
      .tag_q   (tag_s[i+1])
    );
  end

  assign unused_bits = ^{a_s[STAGES][WIDTH-2:0], b_s[STAGES][WIDTH-2:0], op_s[STAGES]};

  // All outputs read zero whenever no result is present.
  always_comb begin
    out_valid    = v[STAGES];
    out_result   = '0;
    out_carry    = 1'b0;
    out_overflow = 1'b0;
    out_zero     = 1'b0;
    out_tag      = '0;
    if (v[STAGES]) begin
      out_result   = sum_s[STAGES];
      out_carry    = c_s[STAGES];
      out_overflow = (a_s[STAGES][WIDTH-1] == b_s[STAGES][WIDTH-1]) &&
                     (sum_s[STAGES][WIDTH-1] != a_s[STAGES][WIDTH-1]);
      out_zero     = ~|sum_s[STAGES];
      out_tag      = tag_s[STAGES];
    end
  end

endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe: vector table, backpressure stream,
// full-rate stream and mid-flight reset.
module tb_adder_pipe;
  import adder_pkg::*;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;
  localparam int TAG_W  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  adder_op_e        in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carry;
  logic             out_overflow;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;

  adder_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_op       (in_op),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_carry   (out_carry),
    .out_overflow(out_overflow),
    .out_zero    (out_zero),
    .out_tag     (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    adder_op_e        op;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] res;
    logic             c;
    logic             o;
    logic             z;
  } vec_t;

  vec_t          vecs [10];
  int            n_checks      = 0;
  int            n_miscompares = 0;
  int            cyc           = 0;
  bit            mon_en        = 1'b0;
  int            mon_count     = 0;
  int            first_out_cyc = 0;
  int            last_out_cyc  = 0;
  bit            prev_stalled  = 1'b0;
  adder_result_s prev_out;
  adder_result_s cur_out;
  adder_result_s exp_item;
  adder_result_s exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input adder_op_e op, input logic [TAG_W-1:0] tag, output int waits);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_tag   = tag;
    waits    = 0;
    @(negedge clk);
    while (!in_ready && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      n_checks++;
      n_miscompares++;
      $display("[TB] FAIL handshake_timeout: in_ready 0 after %0d cycles, required 1", waits);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitOutput(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Scoreboard: accepted inputs queue their golden result, emitted results pop in order.
  always @(negedge clk) begin
    if (!mon_en || rst) begin
      prev_stalled = 1'b0;
    end else begin
      cur_out = '{result: out_result, carry: out_carry, overflow: out_overflow,
                  zero: out_zero, tag: out_tag};
      if (prev_stalled) checkOutput("stall_hold", 64'(cur_out), 64'(prev_out));
      if (in_valid && in_ready) begin
        exp_item     = ref_add(in_a, in_b, in_op);
        exp_item.tag = in_tag;
        exp_q.push_back(exp_item);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_miscompares++;
          $display("[TB] FAIL unexpected_out: got tag %0d result 0x%0h, required no output", out_tag, out_result);
        end else begin
          checkOutput("stream_result", 64'(cur_out), 64'(exp_q.pop_front()));
        end
        mon_count++;
        if (mon_count == 1) first_out_cyc = cyc;
        last_out_cyc = cyc;
      end
      prev_stalled = out_valid && !out_ready;
      prev_out     = cur_out;
    end
  end

  initial begin
    #500000;
    n_miscompares++;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miscompares);
    $finish;
  end

  initial begin
    int waits;
    int lat;

    vecs[0] = '{32'd5,         32'd7,         OP_ADD, 4'd3,  32'd12,        1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF,  32'h00000001,  OP_ADD, 4'd9,  32'h00000000,  1'b1, 1'b0, 1'b1};
    vecs[2] = '{32'h7FFFFFFF,  32'h00000001,  OP_ADD, 4'd10, 32'h80000000,  1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'd3,         32'd5,         OP_SUB, 4'd15, 32'hFFFFFFFE,  1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h80000000,  32'h00000001,  OP_SUB, 4'd1,  32'h7FFFFFFF,  1'b1, 1'b1, 1'b0};
    vecs[5] = '{32'd5,         32'd5,         OP_SUB, 4'd6,  32'h00000000,  1'b1, 1'b0, 1'b1};
    vecs[6] = '{32'h0000FFFF,  32'h00000001,  OP_ADD, 4'd12, 32'h00010000,  1'b0, 1'b0, 1'b0};
    vecs[7] = '{32'h80000000,  32'h80000000,  OP_ADD, 4'd0,  32'h00000000,  1'b1, 1'b1, 1'b1};
    vecs[8] = '{32'h00000000,  32'h80000000,  OP_SUB, 4'd5,  32'h80000000,  1'b0, 1'b1, 1'b0};
    vecs[9] = '{32'h12345678,  32'h0FEDCBA9,  OP_ADD, 4'd14, 32'h22222221,  1'b0, 1'b0, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = OP_ADD;
    in_tag    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid",  64'(out_valid),  64'(0));
    checkOutput("rst_in_ready",   64'(in_ready),   64'(0));
    checkOutput("rst_out_result", 64'(out_result), 64'(0));
    checkOutput("rst_out_zero",   64'(out_zero),   64'(0));
    checkOutput("rst_out_tag",    64'(out_tag),    64'(0));
    rst       = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_in_ready", 64'(in_ready), 64'(1));

    $display("[TB] vector table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].tag, waits);
      waitOutput(lat);
      checkOutput("vec_latency",  64'(lat),          64'(STAGES));
      checkOutput("vec_result",   64'(out_result),   64'(vecs[i].res));
      checkOutput("vec_carry",    64'(out_carry),    64'(vecs[i].c));
      checkOutput("vec_overflow", 64'(out_overflow), 64'(vecs[i].o));
      checkOutput("vec_zero",     64'(out_zero),     64'(vecs[i].z));
      checkOutput("vec_tag",      64'(out_tag),      64'(vecs[i].tag));
    end
    @(posedge clk);
    #1;

    $display("[TB] stream with stall");
    exp_q.delete();
    mon_count = 0;
    mon_en    = 1'b1;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          applyStimulus(32'hFFFFFFF0 + 32'(i), 32'(i) * 32'h10000001,
                        (i % 2 == 1) ? OP_SUB : OP_ADD, 4'(i), waits);
        end
      end
      begin
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("stall_in_ready",  64'(in_ready),  64'(0));
        checkOutput("stall_out_valid", 64'(out_valid), 64'(1));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    for (int k = 0; k < 30 && mon_count < 16; k++) @(posedge clk);
    #1;
    checkOutput("stream_count", 64'(mon_count),    64'(16));
    checkOutput("stream_left",  64'(exp_q.size()), 64'(0));

    $display("[TB] full-rate stream");
    mon_count = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(32'(i) * 32'h01010101, 32'hFEDCBA98 - 32'(i), (i % 3 == 0) ? OP_SUB : OP_ADD,
                    4'(i + 3), waits);
      checkOutput("thru_in_ready_waits", 64'(waits), 64'(0));
    end
    for (int k = 0; k < 30 && mon_count < 20; k++) @(posedge clk);
    #1;
    checkOutput("thru_count", 64'(mon_count),                        64'(20));
    checkOutput("thru_span",  64'(last_out_cyc - first_out_cyc + 1), 64'(20));

    $display("[TB] reset with transactions in flight");
    mon_count = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h11111111 * 32'(i + 1), 32'd1, OP_ADD, 4'(i + 8), waits);
    end
    @(posedge clk);
    #1;
    checkOutput("pre_rst_out_valid", 64'(out_valid), 64'(1));
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    checkOutput("rst_now_out_valid",  64'(out_valid),  64'(0));
    checkOutput("rst_now_out_result", 64'(out_result), 64'(0));
    checkOutput("rst_now_in_ready",   64'(in_ready),   64'(0));
    @(posedge clk);
    #3;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_release_in_ready", 64'(in_ready), 64'(1));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("rst_no_stale", 64'(out_valid), 64'(0));
    end
    @(posedge clk);
    #1;
    applyStimulus(32'd100, 32'd58, OP_SUB, 4'd7, waits);
    waitOutput(lat);
    checkOutput("rst_next_latency", 64'(lat),        64'(STAGES));
    checkOutput("rst_next_result",  64'(out_result), 64'(42));
    checkOutput("rst_next_carry",   64'(out_carry),  64'(1));
    checkOutput("rst_next_tag",     64'(out_tag),    64'(7));
    @(posedge clk);
    #1;
    checkOutput("rst_next_count", 64'(mon_count), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miscompares);
    $finish;
  end

endmodule
